// File: rtl/mm_packet_loader_if.sv
// Host byte stream plus NeuralNetwork write bus for mm_packet_loader.
// The master modport is the loader's view; slave is the host/NeuralNetwork side.
interface mm_packet_loader_if #(
  parameter int MM_DEPTH = 17,
  parameter int MM_SIZE  = 16
);
  logic                in_valid;
  logic [7:0]          in_data;
  logic                in_ready;
  logic                busy;
  logic                write_enable;
  logic [MM_DEPTH-1:0] write_addr;
  logic [MM_SIZE-1:0]  write_data;
  logic [15:0]         frame_count;
  logic                err_flag;

  modport master (
    input  in_valid, in_data, busy,
    output in_ready, write_enable, write_addr, write_data, frame_count, err_flag
  );

  modport slave (
    output in_valid, in_data, busy,
    input  in_ready, write_enable, write_addr, write_data, frame_count, err_flag
  );
endinterface

// File: rtl/mm_packet_loader.sv
// Byte-serial frame loader: A5 sync, 3 address bytes, 2 data bytes -> one write strobe.
// Optional checksum byte (XOR of address and data bytes) enabled by LOADER_CHECKSUM_EN.
module mm_packet_loader #(
  parameter int MM_DEPTH       = 17,
  parameter int MM_SIZE        = 16,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                clk,
  input  logic                reset,
  mm_packet_loader_if.master  bus
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [7:0] SYNC_BYTE = 8'hA5;

`ifdef LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {S_IDLE, S_ADDR, S_DATA, S_CHK, S_ISSUE} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_ADDR, S_DATA, S_ISSUE} state_t;
`endif

  state_t              state;
  state_t              state_next;
  logic [1:0]          byte_idx;
  logic [CNT_W-1:0]    idle_cnt;
  logic [23:0]         addr_shift;
  logic [15:0]         data_shift;
  logic [MM_DEPTH-1:0] addr_hold;
  logic [MM_SIZE-1:0]  data_hold;
  logic [15:0]         frame_cnt;
  logic                err_q;
  logic                ready_state;
  logic                accept;
  logic                collecting;
  logic                timeout_hit;
  logic                frame_error;
  logic                write_strobe;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]          chk_acc;
`endif

  // ready depends on state only, so the handshake never loops back through next-state logic
  assign ready_state = (state != S_ISSUE);
  assign accept      = bus.in_valid && ready_state;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next   = state;
    collecting   = 1'b0;
    timeout_hit  = 1'b0;
    frame_error  = 1'b0;
    write_strobe = 1'b0;

    case (state)
      S_ADDR:  collecting = 1'b1;
      S_DATA:  collecting = 1'b1;
`ifdef LOADER_CHECKSUM_EN
      S_CHK:   collecting = 1'b1;
`endif
      default: collecting = 1'b0;
    endcase

    timeout_hit = collecting && !accept && (idle_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    case (state)
      S_IDLE: begin
        if (accept && (bus.in_data == SYNC_BYTE)) begin
          state_next = S_ADDR;
        end
      end
      S_ADDR: begin
        if (timeout_hit) begin
          state_next  = S_IDLE;
          frame_error = 1'b1;
        end else if (accept && (byte_idx == 2'd2)) begin
          state_next = S_DATA;
        end
      end
      S_DATA: begin
        if (timeout_hit) begin
          state_next  = S_IDLE;
          frame_error = 1'b1;
        end else if (accept && (byte_idx == 2'd1)) begin
`ifdef LOADER_CHECKSUM_EN
          state_next = S_CHK;
`else
          state_next = S_ISSUE;
`endif
        end
      end
`ifdef LOADER_CHECKSUM_EN
      S_CHK: begin
        if (timeout_hit) begin
          state_next  = S_IDLE;
          frame_error = 1'b1;
        end else if (accept) begin
          if (bus.in_data == chk_acc) begin
            state_next = S_ISSUE;
          end else begin
            state_next  = S_IDLE;
            frame_error = 1'b1;
          end
        end
      end
`endif
      S_ISSUE: begin
        if (!bus.busy) begin
          write_strobe = 1'b1;
          state_next   = S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Byte position restarts on every state change; the idle counter restarts on any transfer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      byte_idx <= '0;
      idle_cnt <= '0;
    end else begin
      if (state_next != state) begin
        byte_idx <= '0;
      end else if (accept) begin
        byte_idx <= byte_idx + 2'd1;
      end

      if (collecting && !accept && (state_next == state)) begin
        idle_cnt <= idle_cnt + CNT_W'(1);
      end else begin
        idle_cnt <= '0;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_shift <= '0;
      data_shift <= '0;
    end else begin
      if (accept && (state == S_ADDR)) begin
        addr_shift <= {addr_shift[15:0], bus.in_data};
      end
      if (accept && (state == S_DATA)) begin
        data_shift <= {data_shift[7:0], bus.in_data};
      end
    end
  end

`ifdef LOADER_CHECKSUM_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      chk_acc <= '0;
    end else if (accept && (state == S_IDLE)) begin
      chk_acc <= '0;
    end else if (accept && ((state == S_ADDR) || (state == S_DATA))) begin
      chk_acc <= chk_acc ^ bus.in_data;
    end
  end
`endif

  // The held copies only move on a strobe, so the bus shows the last issued write in between.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_hold <= '0;
      data_hold <= '0;
      frame_cnt <= '0;
      err_q     <= 1'b0;
    end else begin
      if (write_strobe) begin
        addr_hold <= addr_shift[MM_DEPTH-1:0];
        data_hold <= MM_SIZE'(data_shift);
        frame_cnt <= frame_cnt + 16'd1;
      end
      if (frame_error) begin
        err_q <= 1'b1;
      end
    end
  end

  assign bus.in_ready     = ready_state && !reset;
  assign bus.write_enable = write_strobe;
  assign bus.write_addr   = write_strobe ? addr_shift[MM_DEPTH-1:0] : addr_hold;
  assign bus.write_data   = write_strobe ? MM_SIZE'(data_shift) : data_hold;
  assign bus.frame_count  = frame_cnt;
  assign bus.err_flag     = err_q;

endmodule
